// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dm_responder
//  Purpose  : Word-organised data memory that answers CPU load/store requests
//             after a fixed number of wait states with a one-cycle ready
//             pulse, registered read data and an access-error flag.
//  Revision : 1.0  initial release
// ============================================================================
module dm_responder #(
    parameter int ADDR_W = 8,   // word-address bits, depth = 2**ADDR_W words
    parameter int WAIT   = 2    // wait-state cycles, 0..15
) (
    input  logic        clk,
    input  logic        rst,     // synchronous, active-low
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] C_WAIT = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                bad_q, bad_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic [31:0]         mem_q [DEPTH];

    // Access currently being served: live inputs while accepting in IDLE
    // (needed for the zero-wait case), latched copy otherwise.
    logic                w_req_bad;
    logic                w_acc_we;
    logic                w_acc_bad;
    logic [ADDR_W-1:0]   w_acc_idx;
    logic [31:0]         w_acc_wdata;
    logic [3:0]          w_acc_be;
    logic                w_enter_resp;
    logic                w_mem_we;

    // Classify the incoming address: misaligned or beyond the storage depth.
    always_comb begin
        w_req_bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
    end

    // Select between the live request and the latched one.
    always_comb begin
        if (state_q == S_IDLE) begin
            w_acc_we    = we;
            w_acc_bad   = w_req_bad;
            w_acc_idx   = addr[ADDR_W+1:2];
            w_acc_wdata = wdata;
            w_acc_be    = be;
        end else begin
            w_acc_we    = we_q;
            w_acc_bad   = bad_q;
            w_acc_idx   = idx_q;
            w_acc_wdata = wdata_q;
            w_acc_be    = be_q;
        end
    end

    // Next-state and response logic for the IDLE/WAIT/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        bad_d        = bad_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        ready_d      = 1'b0;
        w_enter_resp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    bad_d   = w_req_bad;
                    idx_d   = addr[ADDR_W+1:2];
                    wdata_d = wdata;
                    be_d    = be;
                    cnt_d   = C_WAIT;
                    if (C_WAIT == 4'd0) begin
                        state_d      = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Counter loaded with WAIT; leaving at 1 spends exactly WAIT cycles here.
                if (cnt_q <= 4'd1) begin
                    state_d      = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_enter_resp) begin
            ready_d = 1'b1;
            err_d   = w_acc_bad;
            if (w_acc_bad || w_acc_we) begin
                rdata_d = 32'd0;
            end else begin
                rdata_d = mem_q[w_acc_idx];
            end
        end
    end

    // Stores commit on the edge that enters RESP, only for error-free accesses.
    always_comb begin
        w_mem_we = w_enter_resp && w_acc_we && !w_acc_bad;
    end

    // Sequencer state, latched request and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Storage array: cleared on reset, byte-masked writes otherwise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_acc_be[b]) begin
                    mem_q[w_acc_idx][8*b +: 8] <= w_acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;
    assign ready = ready_q;
    assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_responder
//  Purpose  : Self-checking bench for dm_responder (WAIT=2 and WAIT=0 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_responder;

    localparam int ADDR_W = 8;
    localparam int WAIT2  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // WAIT=2 instance
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        ready, err, busy;

    // WAIT=0 instance
    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] rdata0;
    logic        ready0, err0, busy0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference storage for the WAIT=2 instance: plain array of words.
    logic [31:0] model_mem [1 << ADDR_W];

    dm_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .rdata(rdata), .ready(ready), .err(err), .busy(busy)
    );

    dm_responder #(.ADDR_W(ADDR_W), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .rdata(rdata0), .ready(ready0), .err(err0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour of one access from the specification's rules.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] m, output logic [31:0] rd, output logic e);
        int unsigned widx;
        e  = (a % 4 != 0) || (a >= 32'(4 * (1 << ADDR_W)));
        rd = 32'd0;
        if (!e) begin
            widx = a / 4;
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) model_mem[widx][8*b +: 8] = d[8*b +: 8];
            end else begin
                rd = model_mem[widx];
            end
        end
    endtask

    // One complete transaction; starts and ends at a negedge.
    task automatic txn_check(input bit d0, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] m,
                             input logic [31:0] exp_rd, input logic exp_err,
                             input int exp_lat, input string name);
        logic        r_rdy, r_busy, r_err;
        logic [31:0] r_rd;
        int          lat;
        if (d0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = m; end
        else    begin req  = 1'b1; we  = w; addr  = a; wdata  = d; be  = m; end
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) begin req = 1'b0; req0 = 1'b0; end
            r_rdy  = d0 ? ready0 : ready;
            r_busy = d0 ? busy0  : busy;
            r_rd   = d0 ? rdata0 : rdata;
            r_err  = d0 ? err0   : err;
            if (!r_busy) begin
                chk({name, " busy-in-flight"}, 32'(r_busy), 32'd1);
                break;
            end
            if (r_rdy) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            chk({name, " timeout/latency"}, 32'hFFFF_FFFF, 32'(exp_lat));
        end else begin
            chk({name, " latency"}, 32'(lat), 32'(exp_lat));
            chk({name, " rdata"}, r_rd, exp_rd);
            chk({name, " err"}, 32'(r_err), 32'(exp_err));
            @(negedge clk);
            r_rdy  = d0 ? ready0 : ready;
            r_busy = d0 ? busy0  : busy;
            r_rd   = d0 ? rdata0 : rdata;
            chk({name, " ready-one-cycle"}, 32'(r_rdy), 32'd0);
            chk({name, " idle-after"}, 32'(r_busy), 32'd0);
            chk({name, " rdata-held"}, r_rd, exp_rd);
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t        vecs [14];
        logic [31:0] mrd;
        logic        merr;
        int          rpos [$];

        for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = 32'd0;

        vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0008, 32'hDEADBEEF, 4'b1111, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'b0000, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0008, 32'h11223344, 4'b0101, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,         4'b1111, 32'hDE22BE44, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0004, 32'hAAAA5555, 4'b1111, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0006, 32'hFFFFFFFF, 4'b1111, 32'h0,         1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0004, 32'h0,         4'b0000, 32'hAAAA5555, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0400, 32'h0,         4'b0000, 32'h0,         1'b1};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 32'h12345678, 4'b1111, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h0000_03FC, 32'h0,         4'b0000, 32'h12345678, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_03FC, 32'hFFFFFFFF, 4'b0000, 32'h0,         1'b0};
        vecs[12] = '{1'b0, 32'h0000_03FC, 32'h0,         4'b0000, 32'h12345678, 1'b0};
        vecs[13] = '{1'b0, 32'h8000_0000, 32'h0,         4'b0000, 32'h0,         1'b1};

        // Reset and reset-state outputs
        rst = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset busy",  32'(busy),  32'd0);
        chk("reset rdata", rdata,      32'd0);
        chk("reset err",   32'(err),   32'd0);
        chk("reset0 ready", 32'(ready0), 32'd0);
        chk("reset0 busy",  32'(busy0),  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[i]) begin
            model_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m, mrd, merr);
            txn_check(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].m,
                      vecs[i].exp_rd, vecs[i].exp_err, WAIT2, $sformatf("vec%0d", i));
        end

        // Randomised accesses against the reference model
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, d;
            logic        w;
            logic [3:0]  m;
            int          kind;
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 15)) << 2;
            if (kind == 0) a = a | 32'($urandom_range(1, 3));
            if (kind == 1) a = a | (32'h1 << $urandom_range(10, 31));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            m = 4'($urandom_range(0, 15));
            model_access(w, a, d, m, mrd, merr);
            txn_check(1'b0, w, a, d, m, mrd, merr, WAIT2, $sformatf("rnd%0d", i));
        end

        // Request held high: re-accepted only from IDLE, spacing WAIT+2
        req = 1'b1; we = 1'b0; addr = 32'h0000_0008;
        rpos.delete();
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (ready) rpos.push_back(k);
            if (k == 11) req = 1'b0;
        end
        chk("held count", 32'(rpos.size()), 32'd3);
        if (rpos.size() >= 2) begin
            chk("held first", 32'(rpos[0]), 32'(WAIT2));
            chk("held spacing", 32'(rpos[1] - rpos[0]), 32'(WAIT2 + 2));
        end
        @(negedge clk);

        // WAIT=0 build: ready after the accepting edge, spacing 2 when held
        txn_check(1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 4'b1111, 32'h0, 1'b0, 0, "w0 store");
        txn_check(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 32'hA5A5_0F0F, 1'b0, 0, "w0 load");
        txn_check(1'b1, 1'b0, 32'h0000_0011, 32'h0, 4'b0000, 32'h0, 1'b1, 0, "w0 misalign");
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0000_0010;
        rpos.delete();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            if (ready0) rpos.push_back(k);
            if (k == 7) req0 = 1'b0;
        end
        chk("w0 held count", 32'(rpos.size()), 32'd4);
        if (rpos.size() >= 2) begin
            chk("w0 held first", 32'(rpos[0]), 32'd0);
            chk("w0 held spacing", 32'(rpos[1] - rpos[0]), 32'd2);
        end
        @(negedge clk);

        // Reset during WAIT of a store aborts it and clears storage
        model_access(1'b1, 32'h0000_0008, 32'hCAFEF00D, 4'b1111, mrd, merr);
        txn_check(1'b0, 1'b1, 32'h0000_0008, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, WAIT2, "pre store");
        txn_check(1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, WAIT2, "pre load");
        req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h5555_AAAA; be = 4'b1111;
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        chk("abort busy-before", 32'(busy), 32'd1);
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort ready", 32'(ready), 32'd0);
        chk("abort busy",  32'(busy),  32'd0);
        chk("abort rdata", rdata,      32'd0);
        chk("abort err",   32'(err),   32'd0);
        rst = 1'b1;
        for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = 32'd0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                if (ready) seen++;
            end
            chk("abort no-ready", 32'(seen), 32'd0);
        end
        txn_check(1'b0, 1'b0, 32'h0000_0020, 32'h0, 4'b0000, 32'h0, 1'b0, WAIT2, "post-abort 0x20");
        txn_check(1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'b0000, 32'h0, 1'b0, WAIT2, "post-abort 0x08");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
